// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM state codes, program entry layout, index width.
package counter_seq_pkg;

    localparam int SEQ_DEPTH = 4;
    localparam int SEQ_WIDTH = 8;
    localparam int IDX_W     = $clog2(SEQ_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_STEP   = 3'd5,
        ST_NEXT   = 3'd6
    } state_e;

    typedef struct packed {
        logic [SEQ_WIDTH-1:0] start_val;
        logic [SEQ_WIDTH-1:0] end_val;
        logic                 last;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{start_val: '0, end_val: '0, last: 1'b1};

endpackage

// File: rtl/counter_seq_table.sv
// Program store: DEPTH entries, synchronous write, asynchronous read, reset to {0,0,last}.
module counter_seq_table
    import counter_seq_pkg::*;
#(
    parameter int DEPTH = SEQ_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  entry_t           wdata,
    input  logic [IDX_W-1:0] raddr,
    output entry_t           rdata
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= ENTRY_RESET;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/counter_sequencer.sv
// Segment sequencer for the up/down counter: load start, paced steps until end, then next segment.
//  state  | meaning
//  IDLE   | outputs quiet, waiting for run
//  LOAD   | load strobe with current segment start
//  SETTLE | wait CNT_LAT cycles for cnt_val to follow
//  CHECK  | compare cnt_val with segment end
//  WAIT   | prescaler delay before the next step
//  STEP   | one step pulse
//  NEXT   | advance, loop or finish the program
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int DEPTH   = SEQ_DEPTH,
    parameter int WIDTH   = SEQ_WIDTH,
    parameter int PRESC_W = 8,
    parameter int CNT_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [WIDTH-1:0]   cfg_start,
    input  logic [WIDTH-1:0]   cfg_end,
    input  logic               cfg_last,
    input  logic [PRESC_W-1:0] presc,
    input  logic               run,
    input  logic               loop,
    input  logic [WIDTH-1:0]   cnt_val,
    output logic               cnt_enable,
    output logic               cnt_load,
    output logic [WIDTH-1:0]   cnt_load_val,
    output logic               cnt_up_down,
    output logic               cnt_step,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   seg_idx
);

    localparam int SET_W = $clog2(CNT_LAT) + 1;

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_LOAD   = ST_LOAD;
    localparam logic [2:0] S_SETTLE = ST_SETTLE;
    localparam logic [2:0] S_CHECK  = ST_CHECK;
    localparam logic [2:0] S_WAIT   = ST_WAIT;
    localparam logic [2:0] S_STEP   = ST_STEP;
    localparam logic [2:0] S_NEXT   = ST_NEXT;

    logic [2:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_cnt;
    logic [SET_W-1:0]   settle_cnt;

    entry_t cur;
    entry_t wr_entry;
    logic   table_we;
    logic   dir;
    logic   at_end;
    logic   seg_term;

    assign wr_entry = '{start_val: cfg_start, end_val: cfg_end, last: cfg_last};
    // The table is frozen while a program runs so the active segment cannot change underneath.
    assign table_we = cfg_we && (state == S_IDLE);

    counter_seq_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (table_we),
        .waddr (cfg_addr),
        .wdata (wr_entry),
        .raddr (idx),
        .rdata (cur)
    );

    assign dir      = (cur.end_val >= cur.start_val);
    assign at_end   = (cnt_val == cur.end_val);
    assign seg_term = cur.last || (idx == IDX_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            presc_q    <= '0;
            presc_cnt  <= '0;
            settle_cnt <= '0;
        end else if ((state != S_IDLE) && !run) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        presc_q <= presc;
                        idx     <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    settle_cnt <= SET_W'(CNT_LAT - 1);
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                S_CHECK: begin
                    if (at_end) begin
                        state <= S_NEXT;
                    end else if (presc_q != '0) begin
                        presc_cnt <= presc_q - PRESC_W'(1);
                        state     <= S_WAIT;
                    end else begin
                        state <= S_STEP;
                    end
                end
                S_WAIT: begin
                    if (presc_cnt == '0) begin
                        state <= S_STEP;
                    end else begin
                        presc_cnt <= presc_cnt - PRESC_W'(1);
                    end
                end
                S_STEP: begin
                    settle_cnt <= SET_W'(CNT_LAT - 1);
                    state      <= S_SETTLE;
                end
                S_NEXT: begin
                    if (seg_term) begin
                        idx   <= '0;
                        state <= loop ? S_LOAD : S_IDLE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (state != S_IDLE);
    assign cnt_enable   = busy;
    assign cnt_load     = (state == S_LOAD);
    assign cnt_step     = (state == S_STEP);
    assign cnt_up_down  = busy && dir;
    assign cnt_load_val = busy ? cur.start_val : '0;
    // An abort landing in NEXT must not report completion.
    assign done         = (state == S_NEXT) && run && seg_term && !loop;
    assign seg_idx      = idx;

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomized and directed bench for counter_sequencer against an event-timeline model of the program.
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    localparam int DEPTH   = 4;
    localparam int WIDTH   = 8;
    localparam int PRESC_W = 8;
    localparam int CNT_LAT = 2;
    localparam int K_LOAD  = 0;
    localparam int K_STEP  = 1;
    localparam int K_DONE  = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [IDX_W-1:0]   cfg_addr = '0;
    logic [WIDTH-1:0]   cfg_start = '0;
    logic [WIDTH-1:0]   cfg_end = '0;
    logic               cfg_last = 1'b0;
    logic [PRESC_W-1:0] presc = '0;
    logic               run = 1'b0;
    logic               loop = 1'b0;
    logic [WIDTH-1:0]   cnt_val;
    logic               cnt_enable, cnt_load, cnt_up_down, cnt_step, busy, done;
    logic [WIDTH-1:0]   cnt_load_val;
    logic [IDX_W-1:0]   seg_idx;

    int checks = 0;
    int failures = 0;
    int m_start [DEPTH];
    int m_end   [DEPTH];
    bit m_last  [DEPTH];
    int exp_q [$];
    int act_q [$];

    always #5 clk = ~clk;

    counter_sequencer #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .PRESC_W(PRESC_W), .CNT_LAT(CNT_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_last(cfg_last),
        .presc(presc), .run(run), .loop(loop), .cnt_val(cnt_val),
        .cnt_enable(cnt_enable), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
        .cnt_up_down(cnt_up_down), .cnt_step(cnt_step), .busy(busy), .done(done),
        .seg_idx(seg_idx)
    );

    // Counter model: load visible next cycle, a step shows up CNT_LAT cycles after its pulse.
    logic pend, pend_up;
    always @(posedge clk) begin
        if (!rst_n) begin
            cnt_val <= '0;
            pend    <= 1'b0;
            pend_up <= 1'b0;
        end else begin
            if (pend) cnt_val <= pend_up ? cnt_val + 8'd1 : cnt_val - 8'd1;
            if (cnt_load) cnt_val <= cnt_load_val;
            pend    <= cnt_step;
            pend_up <= cnt_up_down;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int enc(input int cyc, input int kind, input int val);
        return (cyc << 13) | (kind << 11) | val;
    endfunction

    function automatic int outs();
        return int'({busy, cnt_enable, cnt_load, cnt_step, cnt_up_down, done, seg_idx, cnt_load_val});
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_start[i] = 0;
            m_end[i]   = 0;
            m_last[i]  = 1'b1;
        end
    endfunction

    // Timeline from the program rules, offsets relative to the cycle run is raised.
    function automatic void build_expected(input bit lp, input int pv, input int limit, output int done_at);
        int t, idx, tc, st, n, dirb;
        t = 1;
        idx = 0;
        done_at = 0;
        exp_q.delete();
        while (t < limit) begin
            dirb = (m_end[idx] >= m_start[idx]) ? 1 : 0;
            exp_q.push_back(enc(t, K_LOAD, m_start[idx] | (dirb << 8) | (idx << 9)));
            n  = dirb ? m_end[idx] - m_start[idx] : m_start[idx] - m_end[idx];
            tc = t + 1 + CNT_LAT;
            for (int k = 0; k < n; k++) begin
                st = tc + 1 + pv;
                if (st < limit) exp_q.push_back(enc(st, K_STEP, dirb));
                tc = st + 1 + CNT_LAT;
            end
            if (m_last[idx] || idx == DEPTH - 1) begin
                if (lp) begin
                    idx = 0;
                    t   = tc + 2;
                end else begin
                    if (tc + 1 < limit) begin
                        exp_q.push_back(enc(tc + 1, K_DONE, idx));
                        done_at = tc + 1;
                    end
                    break;
                end
            end else begin
                idx++;
                t = tc + 2;
            end
        end
    endfunction

    task automatic write_entry(input int a, input int s, input int e, input bit l);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = IDX_W'(a); cfg_start = 8'(s); cfg_end = 8'(e); cfg_last = l;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_start[a] = s; m_end[a] = e; m_last[a] = l;
    endtask

    task automatic run_check(input string name, input bit lp, input int pv, input int drop_at,
                             input int we_off, input int we_s, input int we_e, input bit we_l);
        int done_at, horizon, bad_en, limit, nmin;
        bit bsy [512];
        presc = 8'(pv);
        loop  = lp;
        if (we_off == 0) begin
            m_start[0] = we_s; m_end[0] = we_e; m_last[0] = we_l;
        end
        limit = (drop_at > 0) ? drop_at : 32'h4000_0000;
        build_expected(lp, pv, limit, done_at);
        horizon = (drop_at > 0) ? drop_at + 4 : ((done_at > 0) ? done_at + 3 : 300);
        act_q.delete();
        bad_en = 0;
        for (int off = 0; off <= horizon && off < 512; off++) begin
            @(posedge clk); #1;
            if (off == 0) run = 1'b1;
            if (drop_at > 0 && off == drop_at) run = 1'b0;
            if (done_at > 0 && off == done_at + 1) run = 1'b0;
            cfg_we = (off == we_off);
            if (off == we_off) begin
                cfg_addr = '0; cfg_start = 8'(we_s); cfg_end = 8'(we_e); cfg_last = we_l;
            end
            @(negedge clk);
            bsy[off] = busy;
            if (cnt_enable != busy) bad_en++;
            if (cnt_load)
                act_q.push_back(enc(off, K_LOAD, int'(cnt_load_val) | (int'(cnt_up_down) << 8) | (int'(seg_idx) << 9)));
            if (cnt_step) act_q.push_back(enc(off, K_STEP, int'(cnt_up_down)));
            if (done) act_q.push_back(enc(off, K_DONE, int'(seg_idx)));
            if (drop_at > 0 && off == drop_at + 1) check({name, ".abort_outputs"}, outs(), 0);
        end
        run = 1'b0;
        cfg_we = 1'b0;
        check({name, ".event_count"}, act_q.size(), exp_q.size());
        nmin = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) check($sformatf("%s.event%0d", name, i), act_q[i], exp_q[i]);
        check({name, ".enable_tracks_busy"}, bad_en, 0);
        if (done_at > 0) begin
            check({name, ".busy_at_done"}, int'(bsy[done_at]), 1);
            check({name, ".busy_after_done"}, int'(bsy[done_at + 1]), 0);
        end
    endtask

    initial begin
        int got;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.outputs", outs(), 0);
        check("reset.busy", int'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // untouched table: single zero-length segment loading 0, done at offset 5
        run_check("t1_default", 1'b0, 0, 0, -1, 0, 0, 1'b0);

        write_entry(0, 5, 8, 1'b1);
        run_check("t2_up3", 1'b0, 3, 0, -1, 0, 0, 1'b0);

        write_entry(0, 10, 7, 1'b0);
        write_entry(1, 0, 2, 1'b1);
        run_check("t3_two_seg", 1'b0, 3, 0, -1, 0, 0, 1'b0);

        // looping program: wrap reload at 46, abort during the WAIT that follows
        run_check("t4_loop_abort", 1'b1, 3, 51, -1, 0, 0, 1'b0);

        write_entry(0, 5, 8, 1'b1);
        run_check("t5_busy_write", 1'b0, 3, 0, 10, 100, 90, 1'b1);
        run_check("t5_table_kept", 1'b0, 3, 0, -1, 0, 0, 1'b0);
        run_check("t5_write_with_run", 1'b0, 2, 0, 0, 20, 22, 1'b1);

        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                int s, e;
                s = int'($urandom_range(5, 250));
                e = s + int'($urandom_range(0, 8)) - 4;
                write_entry(a, s, e, ($urandom_range(0, 9) < 3));
            end
            run_check($sformatf("rand%0d", r), 1'b0, int'($urandom_range(0, 3)), 0, -1, 0, 0, 1'b0);
        end

        // reset while in STEP: outputs quiet next cycle and table back to defaults
        write_entry(0, 5, 8, 1'b1);
        presc = 8'd1;
        loop  = 1'b0;
        @(posedge clk); #1;
        run = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            @(negedge clk);
            if (cnt_step) got = 1;
        end
        check("t6.step_seen", got, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        run = 1'b0;
        @(negedge clk);
        check("t6.outputs_after_reset", outs(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        run_check("t6_table_cleared", 1'b0, 0, 0, -1, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
